// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage with EX/MEM operand forwarding,
// load-use bubble insertion, valid/ready handshakes on both sides and a
// RUN/HALT controller that parks on illegal encodings until flushed.
// Optional feature macro: ID_BRANCH_RESOLVE_EN resolves branches/jumps here
// and drives a one-cycle redirect to fetch.

`ifndef EXE_NOP_OP
`define EXE_NOP_OP          8'h00
`define EXE_AND_OP          8'h24
`define EXE_OR_OP           8'h25
`define EXE_XOR_OP          8'h26
`define EXE_SLL_OP          8'h7C
`define EXE_SRL_OP          8'h02
`define EXE_SRA_OP          8'h03
`define EXE_SLT_OP          8'h2A
`define EXE_SLTU_OP         8'h2B
`define EXE_ADD_OP          8'h20
`define EXE_SUB_OP          8'h22
`define EXE_BLT_OP          8'h40
`define EXE_BGE_OP          8'h41
`define EXE_BLTU_OP         8'h42
`define EXE_BGEU_OP         8'h43
`define EXE_BEQ_OP          8'h51
`define EXE_BNE_OP          8'h52
`define EXE_LB_OP           8'hE0
`define EXE_LH_OP           8'hE1
`define EXE_LW_OP           8'hE3
`define EXE_LBU_OP          8'hE4
`define EXE_LHU_OP          8'hE5
`define EXE_SB_OP           8'hE8
`define EXE_SH_OP           8'hE9
`define EXE_SW_OP           8'hEB
`define EXE_RES_NOP         3'b000
`define EXE_RES_LOGIC       3'b001
`define EXE_RES_SHIFT       3'b010
`define EXE_RES_ARITHMETIC  3'b100
`define EXE_RES_JUMP_BRANCH 3'b110
`define EXE_RES_LOAD_STORE  3'b111
`endif

module id_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [XLEN-1:0]   if_pc_i,
    input  logic [31:0]       if_inst_i,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [XLEN-1:0]   mem_wdata_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   reg1_o,
    output logic [XLEN-1:0]   reg2_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [3:0]        mem_op_o,
    output logic              mem_en_o,
    output logic              wreg_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              illegal_o
`ifdef ID_BRANCH_RESOLVE_EN
    ,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    state_e state_q, state_d;

    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
    logic [7:0]        aluop_q, aluop_d;
    logic [2:0]        alusel_q, alusel_d;
    logic [3:0]        mem_op_q, mem_op_d;
    logic              mem_en_q, mem_en_d, wreg_q, wreg_d;
    logic [REG_AW-1:0] wd_q, wd_d;

    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]   rs1_val, rs2_val;

    logic              dec_illegal, dec_rd1, dec_rd2, dec_mem_en, dec_wreg;
    logic [XLEN-1:0]   dec_reg1, dec_reg2, dec_imm;
    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [3:0]        dec_mem_op;

    logic              hazard, load_en, run, accept, drop;

    assign opcode = if_inst_i[6:0];
    assign funct3 = if_inst_i[14:12];
    assign funct7 = if_inst_i[31:25];
    assign rs1    = REG_AW'(if_inst_i[19:15]);
    assign rs2    = REG_AW'(if_inst_i[24:20]);
    assign rd     = REG_AW'(if_inst_i[11:7]);

    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    assign imm_i = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
    assign imm_s = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
    assign imm_b = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7],
                    if_inst_i[30:25], if_inst_i[11:8], 1'b0};
    assign imm_u = {if_inst_i[31:12], 12'b0};
    assign imm_j = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12],
                    if_inst_i[20], if_inst_i[30:21], 1'b0};

    // Source operand selection: x0 is always zero, then EX, then MEM, then regfile
    always_comb begin
        rs1_val = rs1_data_i;
        rs2_val = rs2_data_i;
        if (rs1 == '0)                          rs1_val = '0;
        else if (ex_wreg_i && ex_wd_i == rs1)   rs1_val = ex_wdata_i;
        else if (mem_wreg_i && mem_wd_i == rs1) rs1_val = mem_wdata_i;
        if (rs2 == '0)                          rs2_val = '0;
        else if (ex_wreg_i && ex_wd_i == rs2)   rs2_val = ex_wdata_i;
        else if (mem_wreg_i && mem_wd_i == rs2) rs2_val = mem_wdata_i;
    end

    // Instruction decode into EX control fields and operands
    always_comb begin
        dec_illegal = 1'b0;
        dec_rd1     = 1'b0;
        dec_rd2     = 1'b0;
        dec_reg1    = '0;
        dec_reg2    = '0;
        dec_imm     = '0;
        dec_aluop   = `EXE_NOP_OP;
        dec_alusel  = `EXE_RES_NOP;
        dec_mem_en  = 1'b0;
        dec_mem_op  = 4'b0;
        dec_wreg    = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_reg1   = (opcode == OPC_AUIPC) ? if_pc_i : '0;
                dec_reg2   = imm_u;
                dec_imm    = imm_u;
                dec_aluop  = `EXE_ADD_OP;
                dec_alusel = `EXE_RES_ARITHMETIC;
                dec_wreg   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_rd1     = (opcode == OPC_JALR);
                dec_illegal = (opcode == OPC_JALR) && (funct3 != 3'b000);
                dec_reg1    = if_pc_i;
                dec_reg2    = XLEN'(4);
                dec_imm     = (opcode == OPC_JALR) ? imm_i : imm_j;
                dec_aluop   = `EXE_ADD_OP;
                dec_alusel  = `EXE_RES_ARITHMETIC;
                dec_wreg    = 1'b1;
            end
            OPC_BRANCH: begin
                dec_rd1    = 1'b1;
                dec_rd2    = 1'b1;
                dec_reg1   = rs1_val;
                dec_reg2   = rs2_val;
                dec_imm    = imm_b;
                dec_alusel = `EXE_RES_JUMP_BRANCH;
                case (funct3)
                    3'b000:  dec_aluop = `EXE_BEQ_OP;
                    3'b001:  dec_aluop = `EXE_BNE_OP;
                    3'b100:  dec_aluop = `EXE_BLT_OP;
                    3'b101:  dec_aluop = `EXE_BGE_OP;
                    3'b110:  dec_aluop = `EXE_BLTU_OP;
                    3'b111:  dec_aluop = `EXE_BGEU_OP;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                dec_rd1    = 1'b1;
                dec_rd2    = (opcode == OPC_STORE);
                dec_reg1   = rs1_val;
                dec_reg2   = (opcode == OPC_STORE) ? rs2_val : '0;
                dec_imm    = (opcode == OPC_STORE) ? imm_s : imm_i;
                dec_alusel = `EXE_RES_LOAD_STORE;
                dec_mem_en = 1'b1;
                dec_mem_op = {(opcode == OPC_STORE), funct3};
                dec_wreg   = (opcode == OPC_LOAD);
                case ({(opcode == OPC_STORE), funct3})
                    4'b0000: dec_aluop = `EXE_LB_OP;
                    4'b0001: dec_aluop = `EXE_LH_OP;
                    4'b0010: dec_aluop = `EXE_LW_OP;
                    4'b0100: dec_aluop = `EXE_LBU_OP;
                    4'b0101: dec_aluop = `EXE_LHU_OP;
                    4'b1000: dec_aluop = `EXE_SB_OP;
                    4'b1001: dec_aluop = `EXE_SH_OP;
                    4'b1010: dec_aluop = `EXE_SW_OP;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_rd1    = 1'b1;
                dec_reg1   = rs1_val;
                dec_reg2   = imm_i;
                dec_imm    = imm_i;
                dec_wreg   = 1'b1;
                dec_alusel = `EXE_RES_ARITHMETIC;
                case (funct3)
                    3'b000: dec_aluop = `EXE_ADD_OP;
                    3'b010: dec_aluop = `EXE_SLT_OP;
                    3'b011: dec_aluop = `EXE_SLTU_OP;
                    3'b100: begin dec_aluop = `EXE_XOR_OP; dec_alusel = `EXE_RES_LOGIC; end
                    3'b110: begin dec_aluop = `EXE_OR_OP;  dec_alusel = `EXE_RES_LOGIC; end
                    3'b111: begin dec_aluop = `EXE_AND_OP; dec_alusel = `EXE_RES_LOGIC; end
                    3'b001: begin
                        dec_aluop   = `EXE_SLL_OP;
                        dec_alusel  = `EXE_RES_SHIFT;
                        dec_illegal = (funct7 != 7'h00);
                    end
                    default: begin
                        dec_aluop   = (funct7 == 7'h20) ? `EXE_SRA_OP : `EXE_SRL_OP;
                        dec_alusel  = `EXE_RES_SHIFT;
                        dec_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                dec_rd1    = 1'b1;
                dec_rd2    = 1'b1;
                dec_reg1   = rs1_val;
                dec_reg2   = rs2_val;
                dec_wreg   = 1'b1;
                dec_alusel = `EXE_RES_ARITHMETIC;
                case ({funct7, funct3})
                    10'h000: dec_aluop = `EXE_ADD_OP;
                    10'h100: dec_aluop = `EXE_SUB_OP;
                    10'h002: dec_aluop = `EXE_SLT_OP;
                    10'h003: dec_aluop = `EXE_SLTU_OP;
                    10'h004: begin dec_aluop = `EXE_XOR_OP; dec_alusel = `EXE_RES_LOGIC; end
                    10'h006: begin dec_aluop = `EXE_OR_OP;  dec_alusel = `EXE_RES_LOGIC; end
                    10'h007: begin dec_aluop = `EXE_AND_OP; dec_alusel = `EXE_RES_LOGIC; end
                    10'h001: begin dec_aluop = `EXE_SLL_OP; dec_alusel = `EXE_RES_SHIFT; end
                    10'h005: begin dec_aluop = `EXE_SRL_OP; dec_alusel = `EXE_RES_SHIFT; end
                    10'h105: begin dec_aluop = `EXE_SRA_OP; dec_alusel = `EXE_RES_SHIFT; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign hazard = ex_wreg_i && ex_is_load_i &&
                    ((dec_rd1 && rs1 != '0 && ex_wd_i == rs1) ||
                     (dec_rd2 && rs2 != '0 && ex_wd_i == rs2));

`ifdef ID_BRANCH_RESOLVE_EN
    logic            redirect_q, redirect_d, br_taken;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d, br_target;

    // Branch condition and target evaluation on the forwarded operands
    always_comb begin
        br_taken = 1'b0;
        if (opcode == OPC_JAL || opcode == OPC_JALR) begin
            br_taken = 1'b1;
        end else if (opcode == OPC_BRANCH) begin
            case (funct3)
                3'b000:  br_taken = (rs1_val == rs2_val);
                3'b001:  br_taken = (rs1_val != rs2_val);
                3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
                3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
                3'b110:  br_taken = (rs1_val <  rs2_val);
                3'b111:  br_taken = (rs1_val >= rs2_val);
                default: br_taken = 1'b0;
            endcase
        end
        if (opcode == OPC_JALR) br_target = (rs1_val + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
        else                    br_target = if_pc_i + dec_imm;
    end

    assign drop          = redirect_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
`else
    assign drop = 1'b0;
`endif

    assign run        = (state_q == ST_RUN);
    assign load_en    = !ex_valid_q || ex_ready_i;
    assign if_ready_o = flush_i || drop || (load_en && run && !hazard);
    assign accept     = if_valid_i && !flush_i && !drop && load_en && run && !hazard;

    // Next-state for the controller and the ID/EX pipeline register
    always_comb begin
        state_d    = state_q;
        ex_valid_d = ex_valid_q;
        pc_d       = pc_q;
        reg1_d     = reg1_q;
        reg2_d     = reg2_q;
        imm_d      = imm_q;
        aluop_d    = aluop_q;
        alusel_d   = alusel_q;
        mem_op_d   = mem_op_q;
        mem_en_d   = mem_en_q;
        wreg_d     = wreg_q;
        wd_d       = wd_q;
`ifdef ID_BRANCH_RESOLVE_EN
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
`endif
        if (flush_i) begin
            state_d    = ST_RUN;
            ex_valid_d = 1'b0;
            mem_en_d   = 1'b0;
            wreg_d     = 1'b0;
        end else if (accept && !dec_illegal) begin
            ex_valid_d = 1'b1;
            pc_d       = if_pc_i;
            reg1_d     = dec_reg1;
            reg2_d     = dec_reg2;
            imm_d      = dec_imm;
            aluop_d    = dec_aluop;
            alusel_d   = dec_alusel;
            mem_op_d   = dec_mem_op;
            mem_en_d   = dec_mem_en;
            wreg_d     = dec_wreg;
            wd_d       = rd;
`ifdef ID_BRANCH_RESOLVE_EN
            redirect_d    = br_taken;
            redirect_pc_d = br_target;
            if (opcode == OPC_BRANCH) begin
                aluop_d  = `EXE_NOP_OP;
                alusel_d = `EXE_RES_NOP;
                wreg_d   = 1'b0;
            end
`endif
        end else if (load_en) begin
            ex_valid_d = 1'b0;
            mem_en_d   = 1'b0;
            wreg_d     = 1'b0;
            if (accept) state_d = ST_HALT;
        end
    end

    // Pipeline and controller registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            ex_valid_q <= 1'b0;
            pc_q       <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
            imm_q      <= '0;
            aluop_q    <= `EXE_NOP_OP;
            alusel_q   <= `EXE_RES_NOP;
            mem_op_q   <= 4'b0;
            mem_en_q   <= 1'b0;
            wreg_q     <= 1'b0;
            wd_q       <= '0;
`ifdef ID_BRANCH_RESOLVE_EN
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            pc_q       <= pc_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            imm_q      <= imm_d;
            aluop_q    <= aluop_d;
            alusel_q   <= alusel_d;
            mem_op_q   <= mem_op_d;
            mem_en_q   <= mem_en_d;
            wreg_q     <= wreg_d;
            wd_q       <= wd_d;
`ifdef ID_BRANCH_RESOLVE_EN
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
`endif
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign pc_o       = pc_q;
    assign reg1_o     = reg1_q;
    assign reg2_o     = reg2_q;
    assign imm_o      = imm_q;
    assign aluop_o    = aluop_q;
    assign alusel_o   = alusel_q;
    assign mem_op_o   = mem_op_q;
    assign mem_en_o   = mem_en_q;
    assign wreg_o     = wreg_q;
    assign wd_o       = wd_q;
    assign illegal_o  = (state_q == ST_HALT);

endmodule
